sm_reg_view_ctrl: RTL and testbench

Controller that owns the CPU's debug register read port (regAddr -> regData) on the board top and produces a stable value for the hex display.

---
 rtl/sm_reg_view_pkg.sv | 17 +
 rtl/sm_reg_view_ctrl_if.sv | 25 ++
 rtl/sm_debounce.sv | 46 ++++
 rtl/sm_reg_view_ctrl.sv | 155 +++++++++++++++
 tb/tb_sm_reg_view_ctrl.sv | 155 +++++++++++++++
 5 files changed

// File: rtl/sm_reg_view_pkg.sv
// Shared types and constants for the register-view controller.
package sm_reg_view_pkg;

  localparam int unsigned REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    MODE_MANUAL = 2'd0,
    MODE_STEP   = 2'd1,
    MODE_SCAN   = 2'd2
  } mode_e;

  typedef enum logic {
    ST_SETTLE = 1'b0,
    ST_TRACK  = 1'b1
  } seq_e;

endpackage

// File: rtl/sm_reg_view_ctrl_if.sv
// Board-side signal bundle of the register-view controller.
interface sm_reg_view_ctrl_if;

  logic [sm_reg_view_pkg::REG_ADDR_W-1:0] swAddr;
  logic                                   btnNext;
  logic                                   btnPrev;
  logic                                   btnMode;
  logic [31:0]                            regData;
  logic [sm_reg_view_pkg::REG_ADDR_W-1:0] regAddr;
  logic [31:0]                            dispData;
  logic [sm_reg_view_pkg::REG_ADDR_W-1:0] dispAddr;
  logic [1:0]                             mode;
  logic                                   valid;

  modport master (
    output swAddr, btnNext, btnPrev, btnMode, regData,
    input  regAddr, dispData, dispAddr, mode, valid
  );

  modport slave (
    input  swAddr, btnNext, btnPrev, btnMode, regData,
    output regAddr, dispData, dispAddr, mode, valid
  );

endinterface

// File: rtl/sm_debounce.sv
// Button conditioner: 2-FF synchronizer, stability counter, one-cycle press pulse.
module sm_debounce #(
  parameter int unsigned DEBOUNCE_W = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic press
);

  logic                  sync1_q, sync2_q;
  logic                  stable_q, stable_d;
  logic [DEBOUNCE_W-1:0] cnt_q, cnt_d;
  logic                  differ, cnt_full;

  always_comb begin
    differ   = sync2_q ^ stable_q;
    cnt_full = &cnt_q;
    stable_d = stable_q;
    cnt_d    = '0;
    // Any agreeing cycle drops the count; 2^DEBOUNCE_W disagreeing cycles flip the level.
    if (differ) begin
      if (cnt_full) begin
        stable_d = ~stable_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    press = differ & cnt_full & ~stable_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= raw;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/sm_reg_view_ctrl.sv
// Owns the CPU debug register read port and publishes a settled value for the hex display.
module sm_reg_view_ctrl
  import sm_reg_view_pkg::*;
#(
  parameter int unsigned DEBOUNCE_W = 16,
  parameter int unsigned DWELL_W    = 24,
  parameter int unsigned SETTLE     = 2
) (
  input logic               clkIn,
  input logic               rst,
  sm_reg_view_ctrl_if.slave bus
);

  localparam logic [2:0] SETTLE_INIT = 3'(SETTLE);

  logic press_next, press_prev, press_mode;

  logic [REG_ADDR_W-1:0] sw1_q, sw2_q;
  mode_e                 mode_q, mode_d;
  logic [REG_ADDR_W-1:0] addr_q, addr_d;
  logic [DWELL_W-1:0]    dwell_q, dwell_d;
  seq_e                  seq_q, seq_d;
  logic [2:0]            settle_q, settle_d;
  logic [31:0]           disp_data_q, disp_data_d;
  logic [REG_ADDR_W-1:0] disp_addr_q, disp_addr_d;
  logic                  valid_q, valid_d;
  logic                  addr_chg;

  sm_debounce #(.DEBOUNCE_W(DEBOUNCE_W)) u_db_next (
    .clk   (clkIn),
    .rst   (rst),
    .raw   (bus.btnNext),
    .press (press_next)
  );

  sm_debounce #(.DEBOUNCE_W(DEBOUNCE_W)) u_db_prev (
    .clk   (clkIn),
    .rst   (rst),
    .raw   (bus.btnPrev),
    .press (press_prev)
  );

  sm_debounce #(.DEBOUNCE_W(DEBOUNCE_W)) u_db_mode (
    .clk   (clkIn),
    .rst   (rst),
    .raw   (bus.btnMode),
    .press (press_mode)
  );

  // Mode and address selection; a mode press swallows any same-cycle Next/Prev.
  always_comb begin
    mode_d  = mode_q;
    addr_d  = addr_q;
    dwell_d = dwell_q;
    if (press_mode) begin
      unique case (mode_q)
        MODE_MANUAL: mode_d = MODE_STEP;
        MODE_STEP: begin
          mode_d  = MODE_SCAN;
          dwell_d = '0;
        end
        MODE_SCAN: begin
          mode_d = MODE_MANUAL;
          addr_d = sw2_q;
        end
        default: mode_d = MODE_MANUAL;
      endcase
    end else begin
      unique case (mode_q)
        MODE_MANUAL: addr_d = sw2_q;
        MODE_STEP: begin
          if (press_next && !press_prev) begin
            addr_d = addr_q + 5'd1;
          end else if (press_prev && !press_next) begin
            addr_d = addr_q - 5'd1;
          end
        end
        MODE_SCAN: begin
          dwell_d = dwell_q + 1'b1;
          if (&dwell_q) begin
            addr_d = addr_q + 5'd1;
          end
        end
        default: mode_d = MODE_MANUAL;
      endcase
    end
  end

  // Settle/capture sequencer: any address change restarts the settle window.
  always_comb begin
    addr_chg    = (addr_d != addr_q);
    seq_d       = seq_q;
    settle_d    = settle_q;
    disp_data_d = disp_data_q;
    disp_addr_d = disp_addr_q;
    valid_d     = valid_q;
    if (addr_chg) begin
      seq_d    = ST_SETTLE;
      settle_d = SETTLE_INIT;
      valid_d  = 1'b0;
    end else begin
      unique case (seq_q)
        ST_SETTLE: begin
          if (settle_q == 3'd0) begin
            seq_d       = ST_TRACK;
            disp_data_d = bus.regData;
            disp_addr_d = addr_q;
            valid_d     = 1'b1;
          end else begin
            settle_d = settle_q - 3'd1;
          end
        end
        ST_TRACK: begin
          disp_data_d = bus.regData;
          disp_addr_d = addr_q;
          valid_d     = 1'b1;
        end
        default: seq_d = ST_SETTLE;
      endcase
    end
  end

  always_ff @(posedge clkIn or posedge rst) begin
    if (rst) begin
      sw1_q       <= '0;
      sw2_q       <= '0;
      mode_q      <= MODE_MANUAL;
      addr_q      <= '0;
      dwell_q     <= '0;
      seq_q       <= ST_SETTLE;
      settle_q    <= SETTLE_INIT;
      disp_data_q <= '0;
      disp_addr_q <= '0;
      valid_q     <= 1'b0;
    end else begin
      sw1_q       <= bus.swAddr;
      sw2_q       <= sw1_q;
      mode_q      <= mode_d;
      addr_q      <= addr_d;
      dwell_q     <= dwell_d;
      seq_q       <= seq_d;
      settle_q    <= settle_d;
      disp_data_q <= disp_data_d;
      disp_addr_q <= disp_addr_d;
      valid_q     <= valid_d;
    end
  end

  assign bus.regAddr  = addr_q;
  assign bus.dispData = disp_data_q;
  assign bus.dispAddr = disp_addr_q;
  assign bus.mode     = mode_q;
  assign bus.valid    = valid_q;

endmodule

// File: tb/tb_sm_reg_view_ctrl.sv
// Randomized bench for sm_reg_view_ctrl against a cycle-level behavioural model.
module tb_sm_reg_view_ctrl;

  localparam int DB  = 2;
  localparam int DW  = 3;
  localparam int ST  = 2;
  localparam int NCYC = 4000;

  logic clkIn = 1'b0;
  logic rst   = 1'b1;
  always #5 clkIn = ~clkIn;

  sm_reg_view_ctrl_if bus ();

  logic [31:0] regfile [32];
  assign bus.regData = regfile[bus.regAddr];

  sm_reg_view_ctrl #(
    .DEBOUNCE_W (DB),
    .DWELL_W    (DW),
    .SETTLE     (ST)
  ) dut (
    .clkIn (clkIn),
    .rst   (rst),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, exp, $time);
  endtask

  // Reference model state: plain integers, addresses taken modulo 32.
  int          m_mode, m_addr, m_dwell, m_age, m_valid, m_daddr;
  logic [31:0] m_ddata;
  int          sw1, sw2;
  int          b1[3], b2[3], bst[3], brun[3];  // index 0=Next, 1=Prev, 2=Mode

  task automatic model_reset();
    m_mode = 0; m_addr = 0; m_dwell = 0; m_age = 0; m_valid = 0; m_daddr = 0;
    m_ddata = '0; sw1 = 0; sw2 = 0;
    for (int i = 0; i < 3; i++) begin
      b1[i] = 0; b2[i] = 0; bst[i] = 0; brun[i] = 0;
    end
  endtask

  task automatic model_step();
    int          pr[3];
    int          raw[3];
    int          na;
    logic [31:0] rd;
    rd = regfile[m_addr];
    for (int i = 0; i < 3; i++)
      pr[i] = (b2[i] != bst[i] && brun[i] + 1 == (1 << DB) && bst[i] == 0) ? 1 : 0;
    na = m_addr;
    if (pr[2] == 1) begin
      if (m_mode == 2) na = sw2;
      m_mode = (m_mode + 1) % 3;
      if (m_mode == 2) m_dwell = 0;
    end else if (m_mode == 0) begin
      na = sw2;
    end else if (m_mode == 1) begin
      if (pr[0] == 1 && pr[1] == 0) na = (na + 1) % 32;
      else if (pr[1] == 1 && pr[0] == 0) na = (na + 31) % 32;
    end else begin
      if (m_dwell == (1 << DW) - 1) na = (na + 1) % 32;
      m_dwell = (m_dwell + 1) % (1 << DW);
    end
    // Display is published once the address has been steady for more than ST edges.
    if (na != m_addr) begin
      m_age = 0;
      m_valid = 0;
    end else begin
      if (m_age < 1000) m_age++;
      if (m_age >= ST + 1) begin
        m_valid = 1; m_ddata = rd; m_daddr = na;
      end
    end
    m_addr = na;
    for (int i = 0; i < 3; i++) begin
      if (b2[i] != bst[i]) begin
        brun[i]++;
        if (brun[i] == (1 << DB)) begin
          bst[i] = 1 - bst[i];
          brun[i] = 0;
        end
      end else begin
        brun[i] = 0;
      end
    end
    raw[0] = int'(bus.btnNext); raw[1] = int'(bus.btnPrev); raw[2] = int'(bus.btnMode);
    for (int i = 0; i < 3; i++) begin
      b2[i] = b1[i];
      b1[i] = raw[i];
    end
    sw2 = sw1;
    sw1 = int'(bus.swAddr);
  endtask

  task automatic check_outputs(input string when);
    check_eq({when, ".regAddr"},  32'(bus.regAddr),  32'(m_addr));
    check_eq({when, ".mode"},     32'(bus.mode),     32'(m_mode));
    check_eq({when, ".valid"},    32'(bus.valid),    32'(m_valid));
    check_eq({when, ".dispAddr"}, 32'(bus.dispAddr), 32'(m_daddr));
    check_eq({when, ".dispData"}, bus.dispData,      m_ddata);
  endtask

  initial begin
    int seg_kind;
    int tog_div;
    for (int i = 0; i < 32; i++) regfile[i] = $urandom;
    bus.swAddr  = 5'd7;
    bus.btnNext = 1'b0;
    bus.btnPrev = 1'b0;
    bus.btnMode = 1'b0;
    model_reset();
    repeat (2) @(negedge clkIn);
    check_outputs("reset");
    rst = 1'b0;

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(posedge clkIn);
      if (!rst) model_step();
      @(negedge clkIn);
      if (rst) rst = 1'b0;
      check_outputs("run");

      if ($urandom_range(499) == 0) begin
        rst = 1'b1;
        model_reset();
        #1;
        check_outputs("async_rst");
      end

      // Segments alternate between busy buttons, paired Next/Prev and long quiet stretches.
      seg_kind = (cyc / 150) % 4;
      tog_div  = (seg_kind == 3) ? 80 : 5;
      if ($urandom_range(tog_div - 1) == 0) bus.btnNext = ~bus.btnNext;
      if (seg_kind == 1) bus.btnPrev = bus.btnNext;
      else if ($urandom_range(tog_div - 1) == 0) bus.btnPrev = ~bus.btnPrev;
      if ($urandom_range(tog_div + 3) == 0) bus.btnMode = ~bus.btnMode;
      if ($urandom_range(24) == 0) bus.swAddr = 5'($urandom);
      if ($urandom_range(7) == 0) regfile[m_addr] = $urandom;
      else if ($urandom_range(9) == 0) regfile[$urandom_range(31)] = $urandom;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
